// File: rtl/crc32_sequencer.sv
// ---------------------------------------------------------------------------
// crc32_sequencer
//
// Execute-stage controller for the CRC32 RISC-MGMT extension. It accepts a
// decoded clear (reset) and start (new_byte) request with a 32-bit source
// word, then folds 1-4 bytes of that word into a running reflected CRC-32
// state, BITS_PER_CYCLE bits per clock. The running state persists across
// operations so multi-word messages can be chained.
//
// Parameters:
//   BITS_PER_CYCLE  CRC bits folded per clock (1, 2, 4 or 8)
//
// Ports:
//   CLK         clock
//   nRST        synchronous active-low reset
//   clear_i     reinitialize CRC state; aborts an in-flight operation
//   start_i     begin processing data_i (accepted in IDLE or DONE)
//   data_i      source word, byte 0 = data_i[7:0] processed first, LSB-first
//   nbytes_i    bytes to process (0-4, values 5-7 clamp to 4)
//   poly_sel_i  (CRC32_POLY_SEL_EN only) 1 selects CRC-32C polynomial
//   busy_o      high while bytes are in flight
//   done_o      one-cycle completion pulse
//   crc_o       finalized CRC (~state)
//
// Optional feature macro: CRC32_POLY_SEL_EN
//   Defined   -> adds poly_sel_i, sampled at start acceptance.
//   Undefined -> polynomial fixed at 0xEDB88320.
// ---------------------------------------------------------------------------
module crc32_sequencer #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        clear_i,
  input  logic        start_i,
  input  logic [31:0] data_i,
  input  logic [2:0]  nbytes_i,
`ifdef CRC32_POLY_SEL_EN
  input  logic        poly_sel_i,
`endif
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] crc_o
);

  localparam int unsigned CRC_W   = 32;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned NB_W    = 3;
  localparam int unsigned SHIFT   = $clog2(BITS_PER_CYCLE);

  localparam logic [CRC_W-1:0] CRC_INIT   = 32'hFFFF_FFFF;
  localparam logic [CRC_W-1:0] POLY_CRC32 = 32'hEDB8_8320;
`ifdef CRC32_POLY_SEL_EN
  localparam logic [CRC_W-1:0] POLY_CRC32C = 32'h82F6_3B78;
`endif

  // Reject unsupported fold widths at elaboration.
  if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 &&
      BITS_PER_CYCLE != 4 && BITS_PER_CYCLE != 8) begin : g_bad_bits_per_cycle
    $error("crc32_sequencer: BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CRC_W-1:0]   crc_q,   crc_d;
  logic [CRC_W-1:0]   data_q,  data_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               busy_q;
  logic               done_q;
  logic [CRC_W-1:0]   poly;
  logic [NB_W-1:0]    nb_clamp;
  logic [CNT_W-1:0]   run_cycles;

`ifdef CRC32_POLY_SEL_EN
  logic               sel_q, sel_d;
`endif

  // Chain BITS_PER_CYCLE single-bit fold steps, consuming data LSB-first.
  function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] st,
                                            input logic [CRC_W-1:0] bits,
                                            input logic [CRC_W-1:0] p);
    logic [CRC_W-1:0] s;
    logic [CRC_W-1:0] b;
    s = st;
    b = bits;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (s[0] ^ b[0]) begin
        s = (s >> 1) ^ p;
      end else begin
        s = s >> 1;
      end
      b = b >> 1;
    end
    return s;
  endfunction

  // Polynomial for the current operation.
`ifdef CRC32_POLY_SEL_EN
  assign poly = sel_q ? POLY_CRC32C : POLY_CRC32;
`else
  assign poly = POLY_CRC32;
`endif

  // Byte count clamp and RUN length (nbytes*8/BITS_PER_CYCLE).
  assign nb_clamp   = (nbytes_i > 3'd4) ? 3'd4 : nbytes_i;
  assign run_cycles = CNT_W'({nb_clamp, 3'b000}) >> SHIFT;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef CRC32_POLY_SEL_EN
    sel_d   = sel_q;
`endif

    case (state_q)
      // DONE accepts a new request exactly like IDLE (back-to-back ops).
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (clear_i) begin
          crc_d = CRC_INIT;
        end
        if (start_i) begin
          data_d  = data_i;
          cnt_d   = run_cycles;
`ifdef CRC32_POLY_SEL_EN
          sel_d   = poly_sel_i;
`endif
          state_d = (run_cycles == '0) ? S_DONE : S_RUN;
        end
      end

      S_RUN: begin
        if (clear_i) begin
          // Abort: no done pulse.
          crc_d   = CRC_INIT;
          state_d = S_IDLE;
        end else begin
          crc_d  = fold(crc_q, data_q, poly);
          data_d = data_q >> BITS_PER_CYCLE;
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; busy/done decoded from next state.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      crc_q   <= CRC_INIT;
      data_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CRC32_POLY_SEL_EN
      sel_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
`ifdef CRC32_POLY_SEL_EN
      sel_q   <= sel_d;
`endif
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign crc_o  = ~crc_q;

endmodule

// File: tb/tb_crc32_sequencer.sv
// ---------------------------------------------------------------------------
// tb_crc32_sequencer
//
// Scoreboard bench for crc32_sequencer. Stimulus pushes the expected CRC and
// RUN length of each operation; an independent monitor pops and compares on
// every done_o pulse. Expected CRCs come from a byte-wise reference CRC.
// Define CRC32_POLY_SEL_EN to also exercise the CRC-32C selection.
// ---------------------------------------------------------------------------
module tb_crc32_sequencer;

  localparam int unsigned BPC      = 1;
  localparam logic [31:0] POLY_STD = 32'hEDB8_8320;
  localparam logic [31:0] POLY_C   = 32'h82F6_3B78;
  localparam logic [31:0] INIT     = 32'hFFFF_FFFF;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        clear_i;
  logic        start_i;
  logic [31:0] data_i;
  logic [2:0]  nbytes_i;
`ifdef CRC32_POLY_SEL_EN
  logic        poly_sel_i;
`endif
  logic        busy_o;
  logic        done_o;
  logic [31:0] crc_o;

  typedef struct {
    logic [31:0] crc;
    int          run;
  } exp_t;

  exp_t        sb[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] model;

  crc32_sequencer #(.BITS_PER_CYCLE(BPC)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .clear_i    (clear_i),
    .start_i    (start_i),
    .data_i     (data_i),
    .nbytes_i   (nbytes_i),
`ifdef CRC32_POLY_SEL_EN
    .poly_sel_i (poly_sel_i),
`endif
    .busy_o     (busy_o),
    .done_o     (done_o),
    .crc_o      (crc_o)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Classic byte-at-a-time reflected CRC over the low nb bytes of word.
  function automatic logic [31:0] ref_crc(input logic [31:0] st, input logic [31:0] word,
                                          input int nb, input bit sel);
    logic [31:0] c;
    logic [31:0] p;
    c = st;
    p = sel ? POLY_C : POLY_STD;
    for (int k = 0; k < nb; k++) begin
      c = c ^ ((word >> (8 * k)) & 32'h0000_00FF);
      for (int j = 0; j < 8; j++) begin
        c = c[0] ? ((c >> 1) ^ p) : (c >> 1);
      end
    end
    return c;
  endfunction

  // Drive one start request at a negedge; returns at the following negedge.
  task automatic issue(input bit clr, input logic [31:0] d, input logic [2:0] nb,
                       input bit sel, input bit track);
    int   nbc;
    exp_t e;
    nbc      = (nb > 3'd4) ? 4 : int'(nb);
    clear_i  = clr;
    start_i  = 1'b1;
    data_i   = d;
    nbytes_i = nb;
`ifdef CRC32_POLY_SEL_EN
    poly_sel_i = sel;
`endif
    if (track) begin
      if (clr) model = INIT;
      model = ref_crc(model, d, nbc, sel);
      e.crc = ~model;
      e.run = (nbc * 8) / int'(BPC);
      sb.push_back(e);
    end
    @(negedge CLK);
    clear_i  = 1'b0;
    start_i  = 1'b0;
    data_i   = $urandom;
    nbytes_i = 3'($urandom);
`ifdef CRC32_POLY_SEL_EN
    poly_sel_i = 1'($urandom);
`endif
  endtask

  // Wait (bounded) until a negedge where done_o is high.
  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (done_o !== 1'b1 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    if (done_o !== 1'b1) check({name, "_timeout"}, 32'(done_o), 32'd1);
  endtask

  // Monitor: count busy cycles and score every done pulse.
  initial begin
    int   run_cnt;
    exp_t e;
    run_cnt = 0;
    forever begin
      @(negedge CLK);
      if (done_o === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("crc_at_done", crc_o, e.crc);
          check("run_len", 32'(run_cnt), 32'(e.run));
        end
        run_cnt = 0;
      end else if (busy_o === 1'b1) begin
        run_cnt++;
      end else begin
        run_cnt = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          clr;
    bit          sel;
    logic [31:0] d;
    logic [2:0]  nb;

    nRST     = 1'b0;
    clear_i  = 1'b0;
    start_i  = 1'b0;
    data_i   = '0;
    nbytes_i = '0;
`ifdef CRC32_POLY_SEL_EN
    poly_sel_i = 1'b0;
`endif
    model = INIT;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_crc", crc_o, 32'h0000_0000);

    // Single byte "a" with clear+start.
    issue(1'b1, 32'h0000_0061, 3'd1, 1'b0, 1'b1);
    wait_done("t1");
    check("crc_a", crc_o, 32'hE8B7_BE43);
    @(negedge CLK);

    // "123456789" chained, back-to-back starts in the DONE cycle.
    issue(1'b1, 32'h3433_3231, 3'd4, 1'b0, 1'b1);
    wait_done("t2a");
    issue(1'b0, 32'h3837_3635, 3'd4, 1'b0, 1'b1);
    wait_done("t2b");
    issue(1'b0, 32'h0000_0039, 3'd1, 1'b0, 1'b1);
    wait_done("t2c");
    check("crc_123456789", crc_o, 32'hCBF4_3926);
    @(negedge CLK);

    // clear_i mid-RUN aborts.
    issue(1'b0, $urandom, 3'd4, 1'b0, 1'b0);
    repeat ((BPC == 1) ? 4 : 2) @(negedge CLK);
    clear_i = 1'b1;
    @(negedge CLK);
    clear_i = 1'b0;
    model   = INIT;
    check("clr_abort_busy", 32'(busy_o), 32'd0);
    check("clr_abort_done", 32'(done_o), 32'd0);
    check("clr_abort_crc", crc_o, 32'h0000_0000);
    repeat (3) @(negedge CLK);

    // nRST mid-RUN aborts.
    issue(1'b0, $urandom, 3'd4, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    nRST  = 1'b1;
    model = INIT;
    check("rst_abort_busy", 32'(busy_o), 32'd0);
    check("rst_abort_done", 32'(done_o), 32'd0);
    check("rst_abort_crc", crc_o, 32'h0000_0000);
    repeat (3) @(negedge CLK);

    // nbytes=0 leaves the CRC unchanged; nbytes=7 behaves as 4.
    issue(1'b1, 32'h0000_0061, 3'd1, 1'b0, 1'b1);
    wait_done("t4a");
    @(negedge CLK);
    issue(1'b0, $urandom, 3'd0, 1'b0, 1'b1);
    wait_done("t4b");
    check("nb0_crc", crc_o, 32'hE8B7_BE43);
    @(negedge CLK);
    issue(1'b1, $urandom, 3'd7, 1'b0, 1'b1);
    wait_done("t4c");
    @(negedge CLK);

    // start_i during RUN is ignored.
    issue(1'b1, $urandom, 3'd4, 1'b0, 1'b1);
    repeat (2) @(negedge CLK);
    start_i  = 1'b1;
    data_i   = $urandom;
    nbytes_i = 3'd1;
    @(negedge CLK);
    start_i  = 1'b0;
    wait_done("t5");
    @(negedge CLK);

`ifdef CRC32_POLY_SEL_EN
    // CRC-32C over "123456789".
    issue(1'b1, 32'h3433_3231, 3'd4, 1'b1, 1'b1);
    wait_done("t6a");
    issue(1'b0, 32'h3837_3635, 3'd4, 1'b1, 1'b1);
    wait_done("t6b");
    issue(1'b0, 32'h0000_0039, 3'd1, 1'b1, 1'b1);
    wait_done("t6c");
    check("crc32c_123456789", crc_o, 32'hE306_9283);
    @(negedge CLK);
`endif

    // Randomized operations, mixed idle gaps and back-to-back starts.
    for (int i = 0; i < 24; i++) begin
      clr = ($urandom_range(0, 3) == 0);
      d   = $urandom;
      nb  = 3'($urandom);
`ifdef CRC32_POLY_SEL_EN
      sel = 1'($urandom);
`else
      sel = 1'b0;
`endif
      issue(clr, d, nb, sel, 1'b1);
      wait_done("rand");
      if ($urandom_range(0, 1) == 1) @(negedge CLK);
    end

    repeat (4) @(negedge CLK);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
